// File: rtl/pipeline_retire.sv
// Retire stage: flushable beat FIFO, valid/ready retire port, id sequence check.
// Optional RETIRE_BYPASS_EN lets a beat retire the same cycle when the FIFO is empty.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

module pipeline_retire #(
    parameter int DEPTH       = 4,
    parameter int STALL_LEVEL = DEPTH,
    parameter int ADDR_W      = `ADDRESS_WIDTH,
    parameter int ID_W        = `ID_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] in_address,
    input  logic [ID_W-1:0]   in_id,
    input  logic              in_valid,
    output logic              out_stall,
    input  logic              in_flush,
    input  logic [ID_W-1:0]   in_flush_id,
    output logic [ADDR_W-1:0] ret_address,
    output logic [ID_W-1:0]   ret_id,
    output logic              ret_valid,
    input  logic              ret_ready,
    output logic              seq_err,
    output logic [7:0]        err_count,
    output logic [15:0]       ret_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ID_W-1:0]   id_q   [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [DEPTH-1:0]  kill_q;
    logic [PW-1:0]     head_q;
    logic [PW-1:0]     tail_q;
    logic [CW-1:0]     count_q;
    logic [ID_W-1:0]   exp_q;

    logic accept, in_kill, in_live;
    logic head_occ, head_kill, head_live;
    logic byp, retire, pop, push, drop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign out_stall = (count_q >= CW'(STALL_LEVEL));
    assign accept    = in_valid && !out_stall;
    assign in_kill   = in_flush && (in_flush_id == in_id);
    assign in_live   = accept && !in_kill;
    assign head_occ  = vld_q[head_q];
    assign head_kill = kill_q[head_q];
    assign head_live = head_occ && !head_kill;
    assign drop      = head_occ && head_kill;

`ifdef RETIRE_BYPASS_EN
    assign byp = in_live && (count_q == '0);
`else
    assign byp = 1'b0;
`endif

    assign ret_valid   = head_live || byp;
    assign ret_address = byp ? in_address : addr_q[head_q];
    assign ret_id      = byp ? in_id : id_q[head_q];
    assign retire      = ret_valid && ret_ready;
    assign pop         = drop || (head_live && ret_ready);
    // A bypassed beat that retires immediately never occupies a slot
    assign push        = in_live && !(byp && ret_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                id_q[i]   <= '0;
            end
            vld_q     <= '0;
            kill_q    <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            exp_q     <= '0;
            seq_err   <= 1'b0;
            err_count <= '0;
            ret_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (in_flush && vld_q[i] && id_q[i] == in_flush_id) begin
                    kill_q[i] <= 1'b1;
                end
            end
            if (pop) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= inc(head_q);
            end
            if (push) begin
                addr_q[tail_q] <= in_address;
                id_q[tail_q]   <= in_id;
                vld_q[tail_q]  <= 1'b1;
                kill_q[tail_q] <= 1'b0;
                tail_q         <= inc(tail_q);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            seq_err <= retire && (ret_id != exp_q);
            if (retire) begin
                exp_q     <= ret_id + 1'b1;
                ret_count <= ret_count + 1'b1;
                if (ret_id != exp_q && err_count != 8'hFF) begin
                    err_count <= err_count + 1'b1;
                end
            end else if (drop) begin
                exp_q <= id_q[head_q] + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_retire.sv
// Scoreboard bench for pipeline_retire: directed beats, flush, stall, wrap, reset.
`timescale 1ns/1ps

module tb_pipeline_retire;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_address = '0;
    logic [3:0] in_id = '0;
    logic       in_valid = 1'b0;
    logic       out_stall;
    logic       in_flush = 1'b0;
    logic [3:0] in_flush_id = '0;
    logic [7:0] ret_address;
    logic [3:0] ret_id;
    logic       ret_valid;
    logic       ret_ready = 1'b0;
    logic       seq_err;
    logic [7:0] err_count;
    logic [15:0] ret_count;

    typedef struct {
        logic [7:0] a;
        logic [3:0] id;
        bit         err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   exp_seq = 1'b0;

    pipeline_retire #(
        .DEPTH(4), .STALL_LEVEL(4), .ADDR_W(8), .ID_W(4)
    ) dut (
        .clk(clk), .reset(reset),
        .in_address(in_address), .in_id(in_id), .in_valid(in_valid),
        .out_stall(out_stall), .in_flush(in_flush), .in_flush_id(in_flush_id),
        .ret_address(ret_address), .ret_id(ret_id), .ret_valid(ret_valid),
        .ret_ready(ret_ready), .seq_err(seq_err),
        .err_count(err_count), .ret_count(ret_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Monitor: pops the scoreboard on every retire, checks the seq_err pulse after it
    always @(negedge clk) begin
        if (reset) begin
            exp_seq = 1'b0;
        end else begin
            chk("seq_err", {31'b0, seq_err}, {31'b0, exp_seq});
            exp_seq = 1'b0;
            if (ret_valid && ret_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_retire_id", {28'b0, ret_id}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("ret_id", {28'b0, ret_id}, {28'b0, e.id});
                    chk("ret_address", {24'b0, ret_address}, {24'b0, e.a});
                    exp_seq = e.err;
                end
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [3:0] id,
                        input bit err, input bit keep, input bit fl);
        int n;
        if (keep) sb.push_back('{a, id, err});
        in_address  = a;
        in_id       = id;
        in_valid    = 1'b1;
        in_flush    = fl;
        in_flush_id = id;
        n = 0;
        @(negedge clk);
        while (out_stall && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", {31'b0, out_stall}, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_flush = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_ret_valid", {31'b0, ret_valid}, 32'd0);
        chk("rst_out_stall", {31'b0, out_stall}, 32'd0);
        chk("rst_ret_count", {16'b0, ret_count}, 32'd0);
        chk("rst_err_count", {24'b0, err_count}, 32'd0);
        chk("rst_ret_id", {28'b0, ret_id}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // In-order stream
        ret_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), 4'(i), 1'b0, 1'b1, 1'b0);
        idle(4);
        chk("t1_ret_count", {16'b0, ret_count}, 32'd4);
        chk("t1_err_count", {24'b0, err_count}, 32'd0);

        // Backpressure at full occupancy
        ret_ready = 1'b0;
        for (int i = 4; i < 8; i++) send(8'h20 + 8'(i), 4'(i), 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("t2_stall_full", {31'b0, out_stall}, 32'd1);
        fork
            send(8'h28, 4'd8, 1'b0, 1'b1, 1'b0);
            begin
                repeat (2) begin
                    @(negedge clk);
                    chk("t2_stall_held", {31'b0, out_stall}, 32'd1);
                end
                chk("t2_no_take", {16'b0, ret_count}, 32'd4);
                @(posedge clk);
                #1;
                ret_ready = 1'b1;
                @(posedge clk);
                @(negedge clk);
                chk("t2_stall_drop", {31'b0, out_stall}, 32'd0);
            end
        join
        idle(6);
        chk("t2_ret_count", {16'b0, ret_count}, 32'd9);

        // Flush of a stored middle entry
        ret_ready = 1'b0;
        send(8'h39, 4'd9, 1'b0, 1'b1, 1'b0);
        send(8'h3A, 4'd10, 1'b0, 1'b0, 1'b0);
        send(8'h3B, 4'd11, 1'b0, 1'b1, 1'b0);
        in_flush    = 1'b1;
        in_flush_id = 4'd10;
        @(negedge clk);
        chk("t3_head_id", {28'b0, ret_id}, 32'd9);
        @(posedge clk);
        #1;
        in_flush = 1'b0;
        ret_ready = 1'b1;
        idle(6);
        chk("t3_ret_count", {16'b0, ret_count}, 32'd11);
        chk("t3_err_count", {24'b0, err_count}, 32'd0);

        // Same-cycle flush of an incoming beat, sequence error, id wrap
        send(8'h4C, 4'd12, 1'b0, 1'b0, 1'b1);
        send(8'h4E, 4'd14, 1'b1, 1'b1, 1'b0);
        send(8'h4F, 4'd15, 1'b0, 1'b1, 1'b0);
        send(8'h50, 4'd0, 1'b0, 1'b1, 1'b0);
        idle(4);
        chk("t4_err_count", {24'b0, err_count}, 32'd1);
        chk("t4_ret_count", {16'b0, ret_count}, 32'd14);

        // Reset with three entries held
        ret_ready = 1'b0;
        for (int i = 1; i < 4; i++) send(8'h60 + 8'(i), 4'(i), 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_ret_valid", {31'b0, ret_valid}, 32'd0);
        chk("t5_out_stall", {31'b0, out_stall}, 32'd0);
        chk("t5_ret_count", {16'b0, ret_count}, 32'd0);
        chk("t5_err_count", {24'b0, err_count}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        ret_ready = 1'b1;
        idle(4);

        // Latency from accept to ret_valid; also confirms expected id restarts at 0
        sb.push_back('{8'h70, 4'd0, 1'b0});
        in_address = 8'h70;
        in_id      = 4'd0;
        in_valid   = 1'b1;
        @(negedge clk);
`ifdef RETIRE_BYPASS_EN
        chk("t6_same_cycle_valid", {31'b0, ret_valid}, 32'd1);
        chk("t6_same_cycle_id", {28'b0, ret_id}, 32'd0);
`else
        chk("t6_same_cycle_valid", {31'b0, ret_valid}, 32'd0);
`endif
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
`ifdef RETIRE_BYPASS_EN
        chk("t6_next_cycle_valid", {31'b0, ret_valid}, 32'd0);
`else
        chk("t6_next_cycle_valid", {31'b0, ret_valid}, 32'd1);
        chk("t6_next_cycle_id", {28'b0, ret_id}, 32'd0);
`endif
        idle(4);
        chk("t6_ret_count", {16'b0, ret_count}, 32'd1);
        chk("t6_err_count", {24'b0, err_count}, 32'd0);
        chk("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
